// File: rtl/vga_line_prefetch_ctrl_pkg.sv
// Shared constants and types for the VGA line prefetch controller.
// Holds the default video mode (active area, sync polarity), the
// frame-buffer geometry (burst length, FIFO depth, address width), the
// FSM state type and a small ceiling-division helper.
package vga_line_prefetch_ctrl_pkg;

  localparam int       DEF_H_ACTIVE   = 1024;
  localparam int       DEF_V_ACTIVE   = 768;
  localparam int       DEF_BURST_LEN  = 256;
  localparam int       DEF_FIFO_DEPTH = 1024;
  localparam int       DEF_ADDR_W     = 24;
  localparam logic     DEF_VS_POL     = 1'b0;

  localparam int       USEDW_W = 11;   // line FIFO fill level width
  localparam int       LEN_W   = 9;    // burst length width (256 -> 9'd256)
  localparam int       UFC_W   = 16;   // underflow counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_ROOM,
    ST_REQ,
    ST_BURST,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/vga_line_prefetch_ctrl_if.sv
// Bus between the prefetch controller and its environment: timing
// generator (v_sync, de), line FIFO (fifo_usedw, fifo_clr), SDRAM arbiter
// read port (rd_req/rd_addr/rd_len/rd_ack/rd_done) and the underflow
// status outputs.
//   master : controller side (drives fifo_clr, rd_*, underflow, uf_count)
//   slave  : environment side
interface vga_line_prefetch_ctrl_if
  import vga_line_prefetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic               v_sync;
  logic               de;
  logic [USEDW_W-1:0] fifo_usedw;
  logic               fifo_clr;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic [LEN_W-1:0]   rd_len;
  logic               rd_ack;
  logic               rd_done;
  logic               underflow;
  logic [UFC_W-1:0]   uf_count;

  modport master (
    input  v_sync, de, fifo_usedw, rd_ack, rd_done,
    output fifo_clr, rd_req, rd_addr, rd_len, underflow, uf_count
  );

  modport slave (
    output v_sync, de, fifo_usedw, rd_ack, rd_done,
    input  fifo_clr, rd_req, rd_addr, rd_len, underflow, uf_count
  );
endinterface

// File: rtl/vga_fs_detect.sv
// Frame-start detector. Registers the vertical sync and emits a one-cycle
// fs pulse on its asserted edge (polarity chosen by VS_POL). The pulse is
// itself registered, so it appears one cycle after the edge is sampled.
// Ports: clk, rst (async, active-high), v_sync in, fs out.
module vga_fs_detect
  import vga_line_prefetch_ctrl_pkg::*;
#(
  parameter logic VS_POL = DEF_VS_POL
) (
  input  logic clk,
  input  logic rst,
  input  logic v_sync,
  output logic fs
);
  logic vs_reg;
  logic fs_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Start in the deasserted level so a sync held inactive gives no pulse.
      vs_reg <= ~VS_POL;
      fs_reg <= 1'b0;
    end else begin
      vs_reg <= v_sync;
      fs_reg <= (v_sync == VS_POL) && (vs_reg != VS_POL);
    end
  end

  assign fs = fs_reg;
endmodule

// File: rtl/vga_line_prefetch_ctrl.sv
// Read-side scheduler between the frame buffer and the display line FIFO.
// Restarts at FRAME_BASE on every frame start, keeps the FIFO topped up
// with burst reads (at most one outstanding, only issued with room for the
// whole burst) and flags FIFO underflow during active video.
// Ports: clk, rst (async, active-high), bus (master modport of
// vga_line_prefetch_ctrl_if).
module vga_line_prefetch_ctrl
  import vga_line_prefetch_ctrl_pkg::*;
#(
  parameter int              H_ACTIVE   = DEF_H_ACTIVE,
  parameter int              V_ACTIVE   = DEF_V_ACTIVE,
  parameter int              BURST_LEN  = DEF_BURST_LEN,
  parameter int              FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
  parameter logic            VS_POL     = DEF_VS_POL
) (
  input  logic clk,
  input  logic rst,
  vga_line_prefetch_ctrl_if.master bus
);
  localparam int TOTAL    = H_ACTIVE * V_ACTIVE;
  localparam int NBURST   = ceil_div(TOTAL, BURST_LEN);
  localparam int LAST_LEN = TOTAL - (NBURST - 1) * BURST_LEN;
  localparam int CNT_W    = $clog2(NBURST + 1);

  localparam logic [CNT_W-1:0] NBURST_C    = CNT_W'(NBURST);
  localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(NBURST - 1);
  localparam logic [LEN_W-1:0] BURST_LEN_C = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] LAST_LEN_C  = LEN_W'(LAST_LEN);

  state_t             state_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               clr_reg;
  logic               req_reg;
  logic               uf_reg;
  logic [UFC_W-1:0]   ufc_reg;

  logic               fs;
  logic [LEN_W-1:0]   cur_len;
  logic [11:0]        room_limit;
  logic               has_room;
  logic               uf_hit;

  vga_fs_detect #(.VS_POL(VS_POL)) u_fs_detect (
    .clk    (clk),
    .rst    (rst),
    .v_sync (bus.v_sync),
    .fs     (fs)
  );

  // Only the final burst of a frame may be short.
  assign cur_len    = (cnt_reg == LAST_IDX_C) ? LAST_LEN_C : BURST_LEN_C;
  assign room_limit = 12'(FIFO_DEPTH) - 12'(cur_len);
  assign has_room   = 12'(bus.fifo_usedw) <= room_limit;
  assign uf_hit     = bus.de && (bus.fifo_usedw == '0) && (state_reg != ST_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= FRAME_BASE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      clr_reg   <= 1'b0;
      req_reg   <= 1'b0;
      uf_reg    <= 1'b0;
      ufc_reg   <= '0;
    end else begin
      // Never true in FLUSH, so it cannot collide with the clear below.
      if (uf_hit) begin
        uf_reg <= 1'b1;
        if (ufc_reg != '1) ufc_reg <= ufc_reg + 1'b1;
      end

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (fs) begin
            clr_reg   <= 1'b1;
            state_reg <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          clr_reg   <= 1'b0;
          addr_reg  <= FRAME_BASE;
          cnt_reg   <= '0;
          uf_reg    <= 1'b0;
          ufc_reg   <= '0;
          state_reg <= ST_ROOM;
        end

        ST_ROOM: begin
          // Length is latched here so it stays put throughout REQ.
          len_reg <= cur_len;
          if (fs) begin
            clr_reg   <= 1'b1;
            state_reg <= ST_FLUSH;
          end else if (cnt_reg == NBURST_C) begin
            state_reg <= ST_DONE;
          end else if (has_room) begin
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (bus.rd_ack) begin
            // A grant is never aborted; a coincident fs is honoured after it drains.
            req_reg   <= 1'b0;
            state_reg <= fs ? ST_DRAIN : ST_BURST;
          end else if (fs) begin
            req_reg   <= 1'b0;
            clr_reg   <= 1'b1;
            state_reg <= ST_FLUSH;
          end
        end

        ST_BURST: begin
          if (bus.rd_done) begin
            addr_reg <= addr_reg + ADDR_W'(len_reg);
            cnt_reg  <= cnt_reg + 1'b1;
            if (fs) begin
              clr_reg   <= 1'b1;
              state_reg <= ST_FLUSH;
            end else begin
              state_reg <= ST_ROOM;
            end
          end else if (fs) begin
            state_reg <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (bus.rd_done) begin
            clr_reg   <= 1'b1;
            state_reg <= ST_FLUSH;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_clr  = clr_reg;
  assign bus.rd_req    = req_reg;
  assign bus.rd_addr   = addr_reg;
  assign bus.rd_len    = len_reg;
  assign bus.underflow = uf_reg;
  assign bus.uf_count  = ufc_reg;
endmodule

// File: tb/tb_vga_line_prefetch_ctrl.sv
// Directed bench for vga_line_prefetch_ctrl. Two instances share clock,
// reset and vertical sync: dut_a runs a 480x272 frame (510 full bursts),
// dut_b a 500x272 frame (532 bursts, last one 64 words). dut_b also takes
// the directed back-pressure, withdrawal, drain, underflow and reset cases.
module tb_vga_line_prefetch_ctrl;

  logic clk;
  logic rst;
  logic v_sync;

  logic [1:0]  de_v;
  logic [1:0]  ack_v;
  logic [1:0]  done_v;
  logic [10:0] usedw_v [2];

  logic [1:0]  req_w;
  logic [23:0] addr_w [2];
  logic [8:0]  len_w  [2];

  int n_checks;
  int n_pass;

  vga_line_prefetch_ctrl_if #(.ADDR_W(24)) bus_a ();
  vga_line_prefetch_ctrl_if #(.ADDR_W(24)) bus_b ();

  assign bus_a.v_sync     = v_sync;
  assign bus_a.de         = de_v[0];
  assign bus_a.fifo_usedw = usedw_v[0];
  assign bus_a.rd_ack     = ack_v[0];
  assign bus_a.rd_done    = done_v[0];
  assign bus_b.v_sync     = v_sync;
  assign bus_b.de         = de_v[1];
  assign bus_b.fifo_usedw = usedw_v[1];
  assign bus_b.rd_ack     = ack_v[1];
  assign bus_b.rd_done    = done_v[1];

  assign req_w[0]  = bus_a.rd_req;
  assign req_w[1]  = bus_b.rd_req;
  assign addr_w[0] = bus_a.rd_addr;
  assign addr_w[1] = bus_b.rd_addr;
  assign len_w[0]  = bus_a.rd_len;
  assign len_w[1]  = bus_b.rd_len;

  vga_line_prefetch_ctrl #(
    .H_ACTIVE(480), .V_ACTIVE(272), .BURST_LEN(256), .FIFO_DEPTH(1024),
    .ADDR_W(24), .FRAME_BASE(24'd0), .VS_POL(1'b0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  vga_line_prefetch_ctrl #(
    .H_ACTIVE(500), .V_ACTIVE(272), .BURST_LEN(256), .FIFO_DEPTH(1024),
    .ADDR_W(24), .FRAME_BASE(24'd0), .VS_POL(1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
      $display("check %-16s got=%0d exp=%0d ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full burst on dut_b from REQ, ending back in REQ at the next address.
  task automatic b_burst();
    ack_v[1] = 1'b1;
    step();
    ack_v[1] = 1'b0;
    done_v[1] = 1'b1;
    step();
    done_v[1] = 1'b0;
    step();
  endtask

  initial begin
    int nb [2];
    int phase [2];
    int cnt [2];
    int exp_addr [2];
    int bad_addr [2];
    int bad_len [2];
    int bad_req [2];
    int last_len [2];
    int last_addr [2];
    int nbursts [2];
    int short_len [2];
    int cyc;
    int bad;
    int exp_len;

    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    v_sync   = 1'b1;
    de_v     = 2'b00;
    ack_v    = 2'b00;
    done_v   = 2'b00;
    usedw_v[0] = 11'd0;
    usedw_v[1] = 11'd0;
    nbursts[0] = 510; short_len[0] = 256;
    nbursts[1] = 532; short_len[1] = 64;

    // Reset state
    repeat (3) step();
    check_value("rst_req",   32'(bus_b.rd_req),    32'd0);
    check_value("rst_addr",  32'(bus_b.rd_addr),   32'd0);
    check_value("rst_len",   32'(bus_b.rd_len),    32'd0);
    check_value("rst_clr",   32'(bus_b.fifo_clr),  32'd0);
    check_value("rst_uf",    32'(bus_b.underflow), 32'd0);
    check_value("rst_ufcnt", 32'(bus_b.uf_count),  32'd0);
    rst = 1'b0;
    step();

    // Underflow: DE high with an empty FIFO for 5 cycles
    de_v[1] = 1'b1;
    repeat (5) step();
    de_v[1] = 1'b0;
    check_value("uf_flag",  32'(bus_b.underflow), 32'd1);
    check_value("uf_count", 32'(bus_b.uf_count),  32'd5);

    // Frame start: FLUSH pulse, status cleared, first request at base
    v_sync = 1'b0;
    step();
    check_value("fs_noclr_yet", 32'(bus_b.fifo_clr), 32'd0);
    step();
    check_value("flush_clr",  32'(bus_b.fifo_clr),  32'd1);
    check_value("flush_uf",   32'(bus_b.underflow), 32'd1);
    v_sync = 1'b1;
    step();
    check_value("clr_1cyc",   32'(bus_b.fifo_clr),  32'd0);
    check_value("fs_uf_clr",  32'(bus_b.underflow), 32'd0);
    check_value("fs_ufc_clr", 32'(bus_b.uf_count),  32'd0);

    // Full frames on both instances: ack 1 cycle after request, done 3 cycles later
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; phase[i] = 0; cnt[i] = 0; exp_addr[i] = 0;
      bad_addr[i] = 0; bad_len[i] = 0; bad_req[i] = 0;
      last_len[i] = 0; last_addr[i] = 0;
    end
    cyc = 0;
    while (!(nb[0] == nbursts[0] && nb[1] == nbursts[1]) && cyc < 20000) begin
      step();
      cyc = cyc + 1;
      ack_v  = 2'b00;
      done_v = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (phase[i] == 0) begin
          if (req_w[i]) begin
            exp_len = (nb[i] == nbursts[i] - 1) ? short_len[i] : 256;
            if (int'(addr_w[i]) != exp_addr[i]) bad_addr[i] = bad_addr[i] + 1;
            if (int'(len_w[i]) != exp_len) bad_len[i] = bad_len[i] + 1;
            last_len[i]  = int'(len_w[i]);
            last_addr[i] = int'(addr_w[i]);
            ack_v[i] = 1'b1;
            phase[i] = 1;
            cnt[i]   = 0;
          end
        end else begin
          if (req_w[i]) bad_req[i] = bad_req[i] + 1;
          cnt[i] = cnt[i] + 1;
          if (cnt[i] == 3) begin
            done_v[i] = 1'b1;
            phase[i]  = 0;
            exp_addr[i] = exp_addr[i] + last_len[i];
            nb[i] = nb[i] + 1;
          end
        end
      end
    end
    step();
    ack_v  = 2'b00;
    done_v = 2'b00;
    check_value("frame_in_time", 32'(cyc < 20000), 32'd1);
    bad = 0;
    repeat (20) begin
      step();
      if (req_w != 2'b00) bad = bad + 1;
    end
    check_value("done_no_req",  32'(bad), 32'd0);
    check_value("a_bursts",     32'(nb[0]), 32'd510);
    check_value("a_addr_err",   32'(bad_addr[0]), 32'd0);
    check_value("a_len_err",    32'(bad_len[0]), 32'd0);
    check_value("a_last_addr",  32'(last_addr[0]), 32'd130304);
    check_value("a_last_len",   32'(last_len[0]), 32'd256);
    check_value("a_one_out",    32'(bad_req[0]), 32'd0);
    check_value("b_bursts",     32'(nb[1]), 32'd532);
    check_value("b_addr_err",   32'(bad_addr[1]), 32'd0);
    check_value("b_len_err",    32'(bad_len[1]), 32'd0);
    check_value("b_last_addr",  32'(last_addr[1]), 32'd135936);
    check_value("b_last_len",   32'(last_len[1]), 32'd64);
    check_value("b_one_out",    32'(bad_req[1]), 32'd0);
    check_value("frame_no_uf",  32'(bus_b.underflow), 32'd0);

    // Back-pressure: 769 words used -> no room for 256; 768 -> request
    usedw_v[1] = 11'd769;
    v_sync = 1'b0;
    step();
    step();
    v_sync = 1'b1;
    step();
    bad = 0;
    repeat (10) begin
      step();
      if (bus_b.rd_req) bad = bad + 1;
    end
    check_value("bp_no_req", 32'(bad), 32'd0);
    usedw_v[1] = 11'd768;
    step();
    check_value("bp_req",  32'(bus_b.rd_req),  32'd1);
    check_value("bp_addr", 32'(bus_b.rd_addr), 32'd0);
    check_value("bp_len",  32'(bus_b.rd_len),  32'd256);

    // Withdrawn request: fs while REQ is pending without ack
    b_burst();
    check_value("wd_pre_addr", 32'(bus_b.rd_addr), 32'd256);
    check_value("wd_pre_req",  32'(bus_b.rd_req),  32'd1);
    v_sync = 1'b0;
    step();
    check_value("wd_req_held", 32'(bus_b.rd_req), 32'd1);
    step();
    check_value("wd_req_drop", 32'(bus_b.rd_req),   32'd0);
    check_value("wd_clr",      32'(bus_b.fifo_clr), 32'd1);
    v_sync = 1'b1;
    step();
    step();
    check_value("wd_next_req",  32'(bus_b.rd_req),  32'd1);
    check_value("wd_next_addr", 32'(bus_b.rd_addr), 32'd0);

    // fs during BURST: drain until done, then flush
    b_burst();
    check_value("dr_pre_addr", 32'(bus_b.rd_addr), 32'd256);
    ack_v[1] = 1'b1;
    step();
    ack_v[1] = 1'b0;
    v_sync = 1'b0;
    step();
    step();
    v_sync = 1'b1;
    bad = 0;
    repeat (100) begin
      step();
      if (bus_b.rd_req || bus_b.fifo_clr) bad = bad + 1;
    end
    check_value("dr_wait", 32'(bad), 32'd0);
    done_v[1] = 1'b1;
    step();
    done_v[1] = 1'b0;
    check_value("dr_clr", 32'(bus_b.fifo_clr), 32'd1);
    step();
    step();
    check_value("dr_next_req",  32'(bus_b.rd_req),  32'd1);
    check_value("dr_next_addr", 32'(bus_b.rd_addr), 32'd0);

    // fs coinciding with ack: grant wins, drain, then flush
    b_burst();
    check_value("ga_pre_addr", 32'(bus_b.rd_addr), 32'd256);
    v_sync = 1'b0;
    step();
    ack_v[1] = 1'b1;
    step();
    ack_v[1] = 1'b0;
    v_sync = 1'b1;
    check_value("ga_req_drop", 32'(bus_b.rd_req),   32'd0);
    check_value("ga_no_clr",   32'(bus_b.fifo_clr), 32'd0);
    bad = 0;
    repeat (5) begin
      step();
      if (bus_b.rd_req || bus_b.fifo_clr) bad = bad + 1;
    end
    check_value("ga_wait", 32'(bad), 32'd0);
    done_v[1] = 1'b1;
    step();
    done_v[1] = 1'b0;
    check_value("ga_clr", 32'(bus_b.fifo_clr), 32'd1);
    step();
    step();
    check_value("ga_next_req",  32'(bus_b.rd_req),  32'd1);
    check_value("ga_next_addr", 32'(bus_b.rd_addr), 32'd0);

    // Reset mid-burst with underflow pending
    b_burst();
    ack_v[1] = 1'b1;
    step();
    ack_v[1] = 1'b0;
    usedw_v[1] = 11'd0;
    de_v[1] = 1'b1;
    repeat (3) step();
    check_value("mb_uf",    32'(bus_b.underflow), 32'd1);
    check_value("mb_ufcnt", 32'(bus_b.uf_count),  32'd3);
    check_value("mb_addr",  32'(bus_b.rd_addr),   32'd256);
    #2;
    rst = 1'b1;
    #1;
    check_value("ar_req",   32'(bus_b.rd_req),    32'd0);
    check_value("ar_addr",  32'(bus_b.rd_addr),   32'd0);
    check_value("ar_len",   32'(bus_b.rd_len),    32'd0);
    check_value("ar_clr",   32'(bus_b.fifo_clr),  32'd0);
    check_value("ar_uf",    32'(bus_b.underflow), 32'd0);
    check_value("ar_ufcnt", 32'(bus_b.uf_count),  32'd0);
    de_v[1] = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
